// File: rtl/mod_pkg.sv
// Shared types and helpers for the residue-arithmetic blocks.
// Holds the FSM state type, clog2 and parameter legality check.
package mod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2, usable in parameter defaults.
  function automatic int clog2(input int v);
    int r;
    longint p;
    r = 0;
    p = 1;
    while (p < longint'(v)) begin
      p = p * 2;
      r++;
    end
    return r;
  endfunction

  // Legal: M >= 2, 0 <= K < M, W >= 1, M <= 2^W.
  function automatic bit params_ok(
    input int m,
    input int k,
    input int w
  );
    bit ok;
    ok = (m >= 2) && (k >= 0) && (k < m) && (w >= 1);
    if (w < 31)
      ok = ok && (m <= (1 << w));
    return ok;
  endfunction

endpackage

// File: rtl/mod_horner_step.sv
// One MSB-first Horner step modulo M: (2*acc + bit*k) mod M.
// Inputs acc, k < M, so two conditional subtractions suffice.
module mod_horner_step
  import mod_pkg::*;
#(
  parameter int M  = 47,
  parameter int ZW = clog2(M)
) (
  input  logic [ZW-1:0] acc_i,
  input  logic          bit_i,
  input  logic [ZW-1:0] k_i,
  output logic [ZW-1:0] acc_o
);

  localparam logic [ZW+1:0] MV = (ZW+2)'(M);

  logic [ZW+1:0] t;
  logic [ZW+1:0] t1;
  logic [ZW+1:0] t2;
  logic [1:0]    unused_hi;

  // Full-width sum, then reduce below M.
  always_comb begin
    t  = {1'b0, acc_i, 1'b0};
    if (bit_i)
      t = t + {2'b00, k_i};
    t1 = (t  >= MV) ? (t  - MV) : t;
    t2 = (t1 >= MV) ? (t1 - MV) : t1;
  end

  assign acc_o     = t2[ZW-1:0];
  assign unused_hi = t2[ZW+1:ZW];

endmodule

// File: rtl/mod_const_mul_serial.sv
// Bit-serial z = (x * K) mod M with valid/ready streaming.
// One Horner step per cycle, W cycles per operand.
module mod_const_mul_serial
  import mod_pkg::*;
#(
  parameter int M  = 47,
  parameter int K  = 21,
  parameter int W  = 6,
  parameter int ZW = clog2(M)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [ZW-1:0] z,
  output logic          busy
);

  if (!params_ok(M, K, W)) begin : g_bad_params
    $error("mod_const_mul_serial: illegal M/K/W");
  end

  localparam int            CW = (W > 1) ? clog2(W) : 1;
  localparam logic [ZW-1:0] KV = ZW'(K);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_e        state_q, state_d;
  logic [ZW-1:0] acc_q, acc_d;
  logic [ZW-1:0] z_q, z_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ZW-1:0] step;

  mod_horner_step #(
    .M  (M),
    .ZW (ZW)
  ) u_step (
    .acc_i (acc_q),
    .bit_i (sh_q[W-1]),
    .k_i   (KV),
    .acc_o (step)
  );

  // Next-state, datapath update and handshake.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    z_d      = z_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sh_d    = x;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step;
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          z_d     = step;
          state_d = DONE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            sh_d    = x;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n)
      in_ready = 1'b0;
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      z_q     <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign z         = z_q;

endmodule

// File: tb/tb_mod_const_mul_serial.sv
// Directed + swept bench for mod_const_mul_serial.
// Scoreboard queue for the default instance, direct checks for variants.
module tb_mod_const_mul_serial;

  localparam int M = 47;
  localparam int K = 21;
  localparam int W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int npass = 0;
  int ntotal = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Default instance
  logic       in_valid = 1'b0;
  logic [5:0] x = '0;
  logic       in_ready, out_valid, busy;
  logic [5:0] z;
  logic       or_man = 1'b1;
  logic       rnd_en = 1'b0;
  logic       rnd_q = 1'b1;
  logic       out_ready;
  assign out_ready = rnd_en ? rnd_q : or_man;

  always @(posedge clk) begin
    #1;
    rnd_q = ($urandom_range(0, 3) != 0);
  end

  mod_const_mul_serial #(.M(M), .K(K), .W(W)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .busy(busy)
  );

  // Variant (M=64, K=5, W=8)
  logic       iv1 = 1'b0;
  logic [7:0] x1 = '0;
  logic       ir1, ov1, b1;
  logic       or1 = 1'b1;
  logic [5:0] z1;

  mod_const_mul_serial #(.M(64), .K(5), .W(8)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1), .x(x1),
    .out_valid(ov1), .out_ready(or1),
    .z(z1), .busy(b1)
  );

  // Variant (M=251, K=250, W=8)
  logic       iv2 = 1'b0;
  logic [7:0] x2 = '0;
  logic       ir2, ov2, b2;
  logic       or2 = 1'b1;
  logic [7:0] z2;

  mod_const_mul_serial #(.M(251), .K(250), .W(8)) u2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv2), .in_ready(ir2), .x(x2),
    .out_valid(ov2), .out_ready(or2),
    .z(z2), .busy(b2)
  );

  // Scoreboard: expected z and accepting edge number
  int sb_z[$];
  int sb_c[$];
  bit lat_done = 1'b0;

  always @(negedge clk) begin
    if (out_valid && !lat_done && sb_c.size() > 0) begin
      chk("latency", cyc - sb_c[0], W);
      lat_done = 1'b1;
    end
    if (out_valid && out_ready) begin
      if (sb_z.size() == 0) begin
        chk("extra_output", 1, 0);
      end else begin
        chk("z", z, sb_z.pop_front());
        void'(sb_c.pop_front());
      end
      lat_done = 1'b0;
    end
  end

  task automatic send(input int v);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    x = 6'(v);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        sb_z.push_back((v * K) % M);
        sb_c.push_back(cyc + 1);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_z.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb_z.size() != 0) chk("drain_timeout", sb_z.size(), 0);
  endtask

  task automatic run1(input int v);
    bit got;
    int lat;
    got = 1'b0;
    iv1 = 1'b1;
    x1 = 8'(v);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = ir1;
    end
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    if (!got) begin
      chk("v1_accept", 0, 1);
      return;
    end
    lat = -1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (ov1) begin
        lat = j - 1;
        break;
      end
    end
    chk("v1_latency", lat, 8);
    chk("v1_z", z1, (v * 5) % 64);
    @(posedge clk);
    #1;
  endtask

  task automatic run2(input int v);
    bit got;
    int lat;
    got = 1'b0;
    iv2 = 1'b1;
    x2 = 8'(v);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = ir2;
    end
    @(posedge clk);
    #1;
    iv2 = 1'b0;
    if (!got) begin
      chk("v2_accept", 0, 1);
      return;
    end
    lat = -1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (ov2) begin
        lat = j - 1;
        break;
      end
    end
    chk("v2_latency", lat, 8);
    chk("v2_z", z2, (v * 250) % 251);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit bad;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_z", z, 0);
    chk("rst_v1_busy", b1, 0);
    chk("rst_v2_busy", b2, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Basic values
    send(1);
    drain();
    send(2);
    drain();
    send(3);
    send(63);
    send(47);
    send(0);
    drain();

    // Back-pressure
    or_man = 1'b0;
    send(3);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("bp_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_z_hold", z, 16);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    or_man = 1'b1;
    send(63);
    drain();

    // Reset mid-operation
    send(63);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_low_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_z.delete();
    sb_c.delete();
    bad = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    chk("abort_no_output", bad, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(1);
    drain();

    // Randomised sweep
    rnd_en = 1'b1;
    for (int v = 0; v < 64; v++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(v);
    end
    drain();
    rnd_en = 1'b0;

    // Parameter variants
    for (int v = 0; v < 256; v++) run1(v);
    for (int v = 0; v < 256; v++) run2(v);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
